// File: rtl/eeg_sample_loader.sv
// Purpose : receives one EEG window of unsigned 16-bit ADC samples and writes them,
//           converted to double-width fixed point, into intermediate-result memory.
// Latency : a write request (mem_wr_en) appears 1 cycle after a sample is accepted.
// Backpressure: adc_ready drops while a buffered write waits for mem_gnt, or once the
//           whole window has been accepted.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort          window start pulse / synchronous soft abort (abort wins)
//   adc_data/valid/ready  sample stream handshake
//   mem_wr_en/addr/data   write request; completes on mem_wr_en && mem_gnt
//   mem_width             always DOUBLE_WIDTH
//   busy, load_done       window in progress / one-cycle pulse after the last write
//   dropped               sticky flag: a sample was offered while idle
module eeg_sample_loader #(
  parameter int NUM_SAMPLES   = 3840,
  parameter int ADDR_W        = 16,
  parameter int BASE_ADDR     = 0,
  parameter int ADC_FRAC_BITS = 12,
  parameter int Q_DOUBLE      = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       adc_data,
  input  logic              adc_valid,
  output logic              adc_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [29:0]       mem_data,
  output logic              mem_width,
  input  logic              mem_gnt,
  output logic              busy,
  output logic              load_done,
  output logic              dropped
);

  localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
  localparam int SHIFT = Q_DOUBLE - ADC_FRAC_BITS;
  localparam logic DOUBLE_WIDTH = 1'b1;

  // The drain phase is not a separate state: it is LOAD with the sample
  // counter at NUM_SAMPLES, which already forces adc_ready low.
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] acc_cnt;   // samples accepted this window
  logic [CNT_W-1:0] wr_idx;    // index of the write currently pending / next to issue
  logic             complete;  // pending write accepted by the arbiter this cycle
  logic             xfer;      // sample accepted this cycle
  logic             last_done; // final write of the window completes this cycle
  logic [29:0]      conv_data;

  assign mem_width = DOUBLE_WIDTH;
  assign busy      = (state == S_LOAD);
  assign mem_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(wr_idx);
  // Code / 2^ADC_FRAC_BITS re-expressed with Q_DOUBLE fractional bits; the
  // largest code stays below the sign bit, so no saturation is required.
  assign conv_data = {14'b0, adc_data} << SHIFT;

  always_comb begin
    complete  = mem_wr_en && mem_gnt;
    // Combinational from mem_gnt so a granted write frees the buffer in the
    // same cycle, giving one sample per cycle when the arbiter keeps up.
    adc_ready = (state == S_LOAD) && (acc_cnt < CNT_W'(NUM_SAMPLES)) &&
                (!mem_wr_en || mem_gnt);
    xfer      = adc_valid && adc_ready;
    last_done = (state == S_LOAD) && complete && (wr_idx == CNT_W'(NUM_SAMPLES - 1));

    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nxt = S_LOAD;
        S_LOAD:  if (last_done) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc_cnt   <= '0;
      wr_idx    <= '0;
      mem_wr_en <= 1'b0;
      mem_data  <= '0;
      load_done <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      state     <= state_nxt;
      load_done <= last_done && !abort;

      // A start that abort overrides does not count, so it leaves dropped alone.
      if ((state == S_IDLE) && start && !abort) begin
        dropped <= 1'b0;
      end else if ((state == S_IDLE) && adc_valid) begin
        dropped <= 1'b1;
      end

      if (abort) begin
        acc_cnt   <= '0;
        wr_idx    <= '0;
        mem_wr_en <= 1'b0;
        mem_data  <= '0;
      end else if (state == S_IDLE) begin
        if (start) begin
          acc_cnt <= '0;
          wr_idx  <= '0;
        end
      end else if (last_done) begin
        acc_cnt   <= '0;
        wr_idx    <= '0;
        mem_wr_en <= 1'b0;
      end else begin
        if (complete) begin
          wr_idx <= wr_idx + CNT_W'(1);
        end
        // A new sample reloads the buffer even while the old one is being
        // granted, keeping mem_wr_en high for back-to-back writes.
        if (xfer) begin
          acc_cnt   <= acc_cnt + CNT_W'(1);
          mem_wr_en <= 1'b1;
          mem_data  <= conv_data;
        end else if (complete) begin
          mem_wr_en <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/eeg_sample_loader.md
Name: eeg_sample_loader

Overview:
- Receiving end of the 16-bit unsigned ADC sample stream that feeds the accelerator during the EEG_LOAD state.
- Accepts one full inference window of NUM_PATCHES*PATCH_LEN = 3840 samples over a valid/ready handshake.
- Converts each sample to double-width intermediate-result fixed point.
- Writes each converted sample into intermediate-result memory starting at EEG_INPUT_MEM (address 0), then signals the top-level controller to start inference.

Parameters:
- NUM_SAMPLES, 3840 (NUM_PATCHES*PATCH_LEN), samples per inference window
- BASE_ADDR, 0 (mem_map[EEG_INPUT_MEM]), first intermediate-result word written
- ADC_FRAC_BITS, 12, fractional bits assigned to the raw ADC code (stored value = code / 2^12)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse from top FSM on entry to EEG_LOAD
- abort  in  1  synchronous soft abort; drops the window
- adc_data  in  16 (AdcData_t)  unsigned ADC sample
- adc_valid  in  1  sample present
- adc_ready  out  1  loader accepts sample this cycle
- mem_wr_en  out  1  write request to intermediate-result memory
- mem_addr  out  IntResAddr_t  write address
- mem_data  out  30 (IntResDouble_t)  converted sample
- mem_width  out  1 (DataWidth_t)  constant DOUBLE_WIDTH
- mem_gnt  in  1  arbiter grant; a write completes on a cycle with mem_wr_en && mem_gnt
- busy  out  1  high in LOAD and DRAIN
- load_done  out  1  one-cycle pulse after the last write completes
- dropped  out  1  sticky; set when adc_valid is seen in IDLE; cleared by start

Behaviour:
- Reset (async, rst_n=0), all outputs and state cleared:
  - state=IDLE; adc_ready=0; mem_wr_en=0; mem_addr=0; mem_data=0.
  - busy=0; load_done=0; dropped=0; sample counter=0; write counter=0.
- mem_width is tied to DOUBLE_WIDTH at all times.
- States:
  - IDLE: start -> LOAD, clears both counters and dropped.
  - LOAD: write counter reaches NUM_SAMPLES-1 and that write completes -> IDLE, with load_done pulsed the next cycle.
  - Once the sample counter reaches NUM_SAMPLES, adc_ready=0 (DRAIN sub-condition) until the pending write completes.
  - abort in any state -> IDLE next cycle: clears pending write and counters; no load_done.
  - start in LOAD/DRAIN is ignored.
- Handshake:
  - adc_ready = (state==LOAD) && (accepted < NUM_SAMPLES) && (!mem_wr_en || mem_gnt). This is a combinational path from mem_gnt.
  - A transfer occurs when adc_valid && adc_ready.
  - adc_data is registered into a single-entry write buffer.
  - mem_wr_en asserts the cycle after the transfer (latency 1).
- Write hold:
  - While mem_wr_en=1 and mem_gnt=0, mem_addr and mem_data hold stable.
  - If mem_gnt=1 and a new transfer happens in the same cycle, the buffer reloads and mem_wr_en stays high. Back-to-back throughput is 1 sample/cycle.
- Address: mem_addr = BASE_ADDR + write index, where write index runs 0..NUM_SAMPLES-1 and increments on each completed write. No wrap.
- Conversion:
  - mem_data = zero-extended adc_data << (Q_STO_INT_RES_DOUBLE - ADC_FRAC_BITS) = << 8.
  - Bit 29 (sign) is always 0; no saturation is needed since the maximum is 0xFFFF<<8 < 2^29.
- Extra samples: after NUM_SAMPLES transfers, adc_ready=0 and adc_valid is ignored; dropped is not set.
- adc_valid in IDLE sets dropped; adc_ready stays 0.
- Simultaneous abort and start: abort wins.
- Simultaneous abort and the last grant: abort wins; no load_done.
- Reset asserted mid-window: immediate return to reset values; memory contents are undefined and not rewritten.

Test Plan:
- Reset then start; stream codes 0..3839 with adc_valid=1 and mem_gnt=1 -> 3840 writes at addresses 0..3839, mem_data = code<<8 (addr 5 -> 0x500), load_done one pulse exactly 1 cycle after the last write, busy falls the same cycle.
- mem_gnt low for 4 cycles while adc_data=0xFFFF is pending -> mem_wr_en held, mem_data=0x0FFFF00 stable, adc_ready=0, no sample lost, write count unchanged.
- Random adc_valid (50%) and random mem_gnt (70%) -> scoreboard matches the input sequence in address order; exactly 3840 writes; one load_done.
- abort after 100 writes -> state IDLE next cycle, mem_wr_en=0, no load_done; next start restarts at address 0.
- adc_valid=1 in IDLE -> dropped=1, adc_ready=0, no writes; start clears dropped to 0.
- rst_n low at sample 2000 -> all outputs 0 asynchronously (same cycle); after release, IDLE with adc_ready=0.
